// File: rtl/symbol_packer.sv
// Bit-stream gearbox: packs IN_W-bit payload words into PHASES-symbol I/Q beats for the mapper.
module symbol_packer #(
  parameter int unsigned PHASES = 16,
  parameter int unsigned WIDTH  = 3,
  parameter int unsigned IN_W   = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [1:0]              modScheme_i,
  input  logic [IN_W-1:0]         data_i,
  input  logic                    valid_i,
  input  logic                    last_i,
  output logic                    ready_o,
  output logic [PHASES*WIDTH-1:0] data_i_o,
  output logic [PHASES*WIDTH-1:0] data_q_o,
  output logic                    valid_o,
  output logic                    last_o,
  input  logic                    ready_i,
  output logic                    busy_o
);

  localparam int unsigned OUT_W = PHASES * WIDTH;
  localparam int unsigned BUF_W = 2 * PHASES * WIDTH + IN_W;
  localparam int unsigned CNT_W = $clog2(BUF_W + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t           state;
  logic [1:0]       mode_r;
  logic [BUF_W-1:0] buf_r;
  logic [CNT_W-1:0] count;

  logic [CNT_W-1:0] need;
  logic [CNT_W-1:0] eff_cnt;
  logic [CNT_W-1:0] base_cnt;
  logic [CNT_W-1:0] cnt_next;
  logic [BUF_W-1:0] buf_next;
  logic             accept;
  logic             emit;
  logic             final_beat;
  logic [OUT_W-1:0] field_i;
  logic [OUT_W-1:0] field_q;

  // Bits consumed per beat for the frame's modulation (reserved code behaves as QPSK).
  always_comb begin
    need = CNT_W'(2 * PHASES);
    case (mode_r)
      2'b10:   need = CNT_W'(4 * PHASES);
      2'b11:   need = CNT_W'(6 * PHASES);
      default: need = CNT_W'(2 * PHASES);
    endcase
  end

  // Handshakes and buffer bookkeeping; in DRAIN a partial tail counts as a full beat
  // because the bits above count are always zero and form the pad.
  always_comb begin
    eff_cnt = count;
    if ((state == DRAIN) && (count != '0) && (count < need)) begin
      eff_cnt = need;
    end
    ready_o    = (state != DRAIN) && ((32'(count) + IN_W) <= BUF_W);
    accept     = valid_i & ready_o;
    emit       = (eff_cnt >= need) & (~valid_o | ready_i);
    base_cnt   = emit ? (eff_cnt - need) : eff_cnt;
    cnt_next   = accept ? (base_cnt + CNT_W'(IN_W)) : base_cnt;
    final_beat = emit && (state == DRAIN) && (base_cnt == '0);
    buf_next   = emit ? (buf_r >> need) : buf_r;
    if (accept) begin
      buf_next = buf_next | (BUF_W'(data_i) << base_cnt);
    end
  end

  // Split the head of the buffer into per-phase I (low half) and Q (high half) fields.
  always_comb begin
    field_i = '0;
    field_q = '0;
    for (int k = 0; k < PHASES; k++) begin
      case (mode_r)
        2'b10: begin
          field_i[2*k +: 2] = buf_r[4*k +: 2];
          field_q[2*k +: 2] = buf_r[4*k+2 +: 2];
        end
        2'b11: begin
          field_i[3*k +: 3] = buf_r[6*k +: 3];
          field_q[3*k +: 3] = buf_r[6*k+3 +: 3];
        end
        default: begin
          field_i[k] = buf_r[2*k];
          field_q[k] = buf_r[2*k+1];
        end
      endcase
    end
  end

  // Frame FSM, bit buffer and registered output beat.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state    <= IDLE;
      mode_r   <= 2'b00;
      buf_r    <= '0;
      count    <= '0;
      data_i_o <= '0;
      data_q_o <= '0;
      valid_o  <= 1'b0;
      last_o   <= 1'b0;
    end else begin
      count <= cnt_next;
      buf_r <= buf_next;

      if (emit) begin
        data_i_o <= field_i;
        data_q_o <= field_q;
        valid_o  <= 1'b1;
        last_o   <= final_beat;
      end else if (ready_i) begin
        valid_o <= 1'b0;
        last_o  <= 1'b0;
      end

      case (state)
        IDLE: begin
          mode_r <= modScheme_i;
          if (accept) begin
            state <= last_i ? DRAIN : RUN;
          end
        end
        RUN: begin
          if (accept && last_i) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (final_beat || (count == '0)) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy_o = (state != IDLE);

endmodule

// File: tb/tb_symbol_packer.sv
// Self-checking bench for symbol_packer: table of frames plus hand-written corner sequences.
module tb_symbol_packer;

  localparam int unsigned PHASES = 16;
  localparam int unsigned WIDTH  = 3;
  localparam int unsigned IN_W   = 32;
  localparam int unsigned OUT_W  = PHASES * WIDTH;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic [1:0]       modScheme_i;
  logic [IN_W-1:0]  data_i;
  logic             valid_i;
  logic             last_i;
  logic             ready_o;
  logic [OUT_W-1:0] data_i_o;
  logic [OUT_W-1:0] data_q_o;
  logic             valid_o;
  logic             last_o;
  logic             ready_i;
  logic             busy_o;

  always #5 clk_i = ~clk_i;

  symbol_packer #(.PHASES(PHASES), .WIDTH(WIDTH), .IN_W(IN_W)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .modScheme_i (modScheme_i),
    .data_i      (data_i),
    .valid_i     (valid_i),
    .last_i      (last_i),
    .ready_o     (ready_o),
    .data_i_o    (data_i_o),
    .data_q_o    (data_q_o),
    .valid_o     (valid_o),
    .last_o      (last_o),
    .ready_i     (ready_i),
    .busy_o      (busy_o)
  );

  typedef struct packed {
    logic [OUT_W-1:0] i;
    logic [OUT_W-1:0] q;
    logic             last;
  } beat_t;

  typedef struct {
    logic [1:0]       mode;
    int               nw;
    logic [31:0]      w;
    int               beats;
    logic [OUT_W-1:0] ei;
    logic [OUT_W-1:0] eq;
  } vec_t;

  beat_t            sb[$];
  int               checks = 0;
  int               errors = 0;
  int               beats_seen = 0;
  logic [OUT_W-1:0] last_i_seen;
  logic [OUT_W-1:0] last_q_seen;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: serialise words LSB first, zero-pad to whole beats, slice into I/Q fields.
  function automatic void model_frame(input logic [1:0] mode, input logic [31:0] words[$]);
    bit    bits[$];
    int    b;
    int    need;
    int    nbeats;
    beat_t bt;
    b = (mode == 2'b11) ? 3 : (mode == 2'b10) ? 2 : 1;
    need = 2 * b * PHASES;
    foreach (words[w]) begin
      for (int j = 0; j < IN_W; j++) bits.push_back(words[w][j]);
    end
    nbeats = (bits.size() + need - 1) / need;
    while (bits.size() < nbeats * need) bits.push_back(1'b0);
    for (int n = 0; n < nbeats; n++) begin
      bt.i = '0;
      bt.q = '0;
      bt.last = (n == nbeats - 1);
      for (int k = 0; k < PHASES; k++) begin
        for (int j = 0; j < b; j++) begin
          bt.i[k*b + j] = bits[n*need + k*2*b + j];
          bt.q[k*b + j] = bits[n*need + k*2*b + b + j];
        end
      end
      sb.push_back(bt);
    end
  endfunction

  // Output monitor: scoreboard compare on each transfer, stability check while stalled.
  logic             hold_p = 1'b0;
  logic [OUT_W-1:0] hold_i;
  logic [OUT_W-1:0] hold_q;
  logic             hold_l;
  beat_t            exp_b;

  always @(negedge clk_i) begin
    if (!rst_i) begin
      hold_p = 1'b0;
    end else begin
      if (hold_p) begin
        check("hold_i", 64'(data_i_o), 64'(hold_i));
        check("hold_q", 64'(data_q_o), 64'(hold_q));
        check("hold_last", 64'(last_o), 64'(hold_l));
        check("hold_valid", 64'(valid_o), 64'd1);
      end
      if (valid_o && ready_i) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got i=%h q=%h expected no beat", data_i_o, data_q_o);
        end else begin
          exp_b = sb.pop_front();
          check("beat_i", 64'(data_i_o), 64'(exp_b.i));
          check("beat_q", 64'(data_q_o), 64'(exp_b.q));
          check("beat_last", 64'(last_o), 64'(exp_b.last));
        end
        beats_seen++;
        if (last_o) begin
          last_i_seen = data_i_o;
          last_q_seen = data_q_o;
        end
      end
      hold_p = valid_o && !ready_i;
      hold_i = data_i_o;
      hold_q = data_q_o;
      hold_l = last_o;
    end
  end

  task automatic send_frame(input logic [1:0] mode, input logic [31:0] words[$], input bit toggle);
    logic rdy;
    int   budget;
    modScheme_i = mode;
    foreach (words[w]) begin
      budget  = 0;
      valid_i = 1'b1;
      data_i  = words[w];
      last_i  = (w == words.size() - 1);
      forever begin
        @(negedge clk_i);
        rdy = ready_o;
        @(posedge clk_i);
        #1;
        if (rdy) break;
        budget++;
        if (budget > 200) begin
          checks++;
          errors++;
          $display("FAIL accept_timeout: got ready_o=0 expected word %0d accepted", w);
          valid_i = 1'b0;
          last_i  = 1'b0;
          return;
        end
      end
      if (toggle && (w == 0)) modScheme_i = ~mode;
    end
    valid_i = 1'b0;
    last_i  = 1'b0;
    data_i  = '0;
  endtask

  task automatic wait_done();
    int n;
    for (n = 0; n < 300; n++) begin
      @(posedge clk_i);
      #2;
      if ((sb.size() == 0) && !busy_o && !valid_o) break;
    end
    check("frame_done", 64'(n < 300), 64'd1);
  endtask

  vec_t        tbl[6];
  logic [31:0] wq[$];

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected bench completion");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{2'b00, 1, 32'hA5A5_A5A5, 1, 48'h0000_0000_3333, 48'h0000_0000_CCCC};
    tbl[1] = '{2'b11, 3, 32'hFFFF_FFFF, 1, 48'hFFFF_FFFF_FFFF, 48'hFFFF_FFFF_FFFF};
    tbl[2] = '{2'b10, 1, 32'hFFFF_FFFF, 1, 48'h0000_0000_FFFF, 48'h0000_0000_FFFF};
    tbl[3] = '{2'b01, 2, 32'hFFFF_0000, 2, 48'h0000_0000_FF00, 48'h0000_0000_FF00};
    tbl[4] = '{2'b11, 1, 32'h0000_0FFF, 1, 48'h0000_0000_003F, 48'h0000_0000_003F};
    tbl[5] = '{2'b10, 3, 32'h5555_5555, 2, 48'h0000_0000_5555, 48'h0000_0000_5555};

    rst_i = 1'b0;
    modScheme_i = 2'b00;
    data_i = '0;
    valid_i = 1'b0;
    last_i = 1'b0;
    ready_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b1;
    @(negedge clk_i);
    check("rst_valid", 64'(valid_o), 64'd0);
    check("rst_last", 64'(last_o), 64'd0);
    check("rst_data_i", 64'(data_i_o), 64'd0);
    check("rst_data_q", 64'(data_q_o), 64'd0);
    check("rst_ready", 64'(ready_o), 64'd1);
    check("rst_busy", 64'(busy_o), 64'd0);
    @(posedge clk_i);
    #1;

    // Table-driven frames of repeated words.
    for (int t = 0; t < 6; t++) begin
      wq.delete();
      for (int n = 0; n < tbl[t].nw; n++) wq.push_back(tbl[t].w);
      beats_seen = 0;
      model_frame(tbl[t].mode, wq);
      send_frame(tbl[t].mode, wq, 1'b0);
      wait_done();
      check("tbl_beats", 64'(beats_seen), 64'(tbl[t].beats));
      check("tbl_last_i", 64'(last_i_seen), 64'(tbl[t].ei));
      check("tbl_last_q", 64'(last_q_seen), 64'(tbl[t].eq));
      check("tbl_ready", 64'(ready_o), 64'd1);
    end

    // Backpressure: buffer fills, one beat held, then drains one beat per cycle.
    wq.delete();
    for (int n = 0; n < 8; n++) wq.push_back(32'h1000_0000 + 32'(n) * 32'h0101_0101);
    beats_seen = 0;
    model_frame(2'b00, wq);
    ready_i = 1'b0;
    fork
      send_frame(2'b00, wq, 1'b0);
      begin
        repeat (12) @(posedge clk_i);
        #2;
        check("stall_valid", 64'(valid_o), 64'd1);
        check("stall_ready_o", 64'(ready_o), 64'd0);
        check("stall_busy", 64'(busy_o), 64'd1);
        ready_i = 1'b1;
        for (int c = 0; c < 4; c++) begin
          @(negedge clk_i);
          check("stream_valid", 64'(valid_o), 64'd1);
        end
      end
    join
    wait_done();
    check("stall_beats", 64'(beats_seen), 64'd8);

    // Mode change mid-frame is ignored; the following frame picks up the new mode.
    wq.delete();
    for (int n = 0; n < 4; n++) wq.push_back(32'hC3A5_0F96 ^ (32'(n) << 4));
    beats_seen = 0;
    model_frame(2'b10, wq);
    send_frame(2'b10, wq, 1'b1);
    wait_done();
    check("toggle_beats", 64'(beats_seen), 64'd2);
    check("toggle_mode_in", 64'(modScheme_i), 64'd1);
    wq.delete();
    wq.push_back(32'h1234_5678);
    beats_seen = 0;
    model_frame(2'b01, wq);
    send_frame(modScheme_i, wq, 1'b0);
    wait_done();
    check("newmode_beats", 64'(beats_seen), 64'd1);

    // Reset mid-frame with a beat pending.
    ready_i = 1'b0;
    modScheme_i = 2'b00;
    @(posedge clk_i);
    #1 valid_i = 1'b1; data_i = 32'hDEAD_BEEF; last_i = 1'b0;
    @(posedge clk_i);
    #1 data_i = 32'h0BAD_F00D;
    @(posedge clk_i);
    #1 valid_i = 1'b0;
    check("pre_rst_valid", 64'(valid_o), 64'd1);
    check("pre_rst_busy", 64'(busy_o), 64'd1);
    #2 rst_i = 1'b0;
    #1;
    check("mid_rst_valid", 64'(valid_o), 64'd0);
    check("mid_rst_busy", 64'(busy_o), 64'd0);
    check("mid_rst_last", 64'(last_o), 64'd0);
    @(posedge clk_i);
    #1 rst_i = 1'b1;
    ready_i = 1'b1;
    @(negedge clk_i);
    check("post_rst_ready", 64'(ready_o), 64'd1);
    check("post_rst_busy", 64'(busy_o), 64'd0);
    check("post_rst_valid", 64'(valid_o), 64'd0);
    @(posedge clk_i);
    #1;
    wq.delete();
    wq.push_back(32'hA5A5_A5A5);
    beats_seen = 0;
    model_frame(2'b00, wq);
    send_frame(2'b00, wq, 1'b0);
    wait_done();
    check("post_rst_beats", 64'(beats_seen), 64'd1);
    check("post_rst_last_i", 64'(last_i_seen), 64'h0000_0000_3333);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
